alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 117 +++++++++++
 tb/tb_alu_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// One operation in flight; the ALU result is sampled after SETTLE_CYCLES.
module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [2:0]  req0_op,
    input  logic [2:0]  req1_op,
    input  logic [15:0] req0_x,
    input  logic [15:0] req0_y,
    input  logic [15:0] req1_x,
    input  logic [15:0] req1_y,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_s,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy
);
    localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_last;
    logic [15:0] r_alu_x, r_alu_y, r_data;
    logic [2:0]  r_alu_op;
    logic        r_id, r_err;

    logic        w_any, w_gnt, w_xfer, w_legal;
    logic [2:0]  w_op;
    logic [15:0] w_x, w_y;

    // Tie goes to whoever was not served last; a lone requester always wins.
    assign w_any   = req0_valid | req1_valid;
    assign w_gnt   = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_xfer  = (r_state == IDLE) & w_any & ~rst;
    assign w_op    = w_gnt ? req1_op : req0_op;
    assign w_x     = w_gnt ? req1_x  : req0_x;
    assign w_y     = w_gnt ? req1_y  : req0_y;
    assign w_legal = (w_op == 3'b000) | (w_op == 3'b001) |
                     (w_op == 3'b010) | (w_op == 3'b110);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_xfer) w_next = w_legal ? SETTLE : RESP;
            SETTLE:  if (r_cnt == 4'd1) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = w_xfer & ~w_gnt;
        req1_ready = w_xfer &  w_gnt;
        busy       = (r_state != IDLE);
        rsp_valid  = (r_state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_last   <= 1'b1;
            r_alu_x  <= '0;
            r_alu_y  <= '0;
            r_alu_op <= '0;
            r_data   <= '0;
            r_id     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_last <= w_gnt;
                r_id   <= w_gnt;
                if (w_legal) begin
                    r_alu_x  <= w_x;
                    r_alu_y  <= w_y;
                    r_alu_op <= w_op;
                    r_cnt    <= LP_SETTLE;
                end else begin
                    // Illegal opcodes never reach the ALU; the old operands stay put.
                    r_data <= '0;
                    r_err  <= 1'b1;
                end
            end
            if (r_state == SETTLE) begin
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_data <= alu_s;
                    r_err  <= 1'b0;
                end
            end
        end
    end

    assign alu_x    = r_alu_x;
    assign alu_y    = r_alu_y;
    assign alu_op   = r_alu_op;
    assign rsp_id   = r_id;
    assign rsp_data = r_data;
    assign rsp_err  = r_err;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (settle 1 and 3) each driving a bench ALU,
// checked every cycle against a transaction-timeline model plus literal checks.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v0[2], v1[2], rr[2];
    logic [2:0]  op0[2], op1[2];
    logic [15:0] x0[2], y0[2], x1[2], y1[2];
    logic        rdy0[2], rdy1[2], rv[2], rid[2], rerr[2], bsy[2];
    logic [15:0] ax[2], ay[2], as[2], rdata[2];
    logic [2:0]  aop[2];

    int n_checks = 0;
    int n_errs   = 0;

    function automatic logic [15:0] alu_f(logic [15:0] x, logic [15:0] y, logic [2:0] op);
        case (op)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x + y;
            3'b110:  return x - y;
            default: return 16'hDEAD;
        endcase
    endfunction

    function automatic logic legal(logic [2:0] op);
        return op inside {3'b000, 3'b001, 3'b010, 3'b110};
    endfunction

    function automatic int settle(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign as[g] = alu_f(ax[g], ay[g], aop[g]);
        alu_arbiter #(.SETTLE_CYCLES((g == 0) ? 1 : 3)) u_dut (
            .clk(clk), .rst(rst),
            .req0_valid(v0[g]), .req1_valid(v1[g]),
            .req0_ready(rdy0[g]), .req1_ready(rdy1[g]),
            .req0_op(op0[g]), .req1_op(op1[g]),
            .req0_x(x0[g]), .req0_y(y0[g]), .req1_x(x1[g]), .req1_y(y1[g]),
            .alu_x(ax[g]), .alu_y(ay[g]), .alu_op(aop[g]), .alu_s(as[g]),
            .rsp_valid(rv[g]), .rsp_ready(rr[g]),
            .rsp_id(rid[g]), .rsp_data(rdata[g]), .rsp_err(rerr[g]), .busy(bsy[g])
        );
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: an accepted op becomes visible a fixed number of edges later and
    // stays until consumed; the requester is chosen by the round-robin rule.
    logic        m_inf[2], m_last[2], m_id[2], m_err[2];
    logic [15:0] m_data[2], m_ax[2], m_ay[2];
    logic [2:0]  m_aop[2];
    int          m_n;
    int          m_rn[2];
    logic        mvld[2], mg[2], mev[2];
    logic [2:0]  mop[2];
    logic [15:0] mx[2], my[2];

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            mvld[d] = v0[d] | v1[d];
            mg[d]   = (v0[d] && v1[d]) ? !m_last[d] : v1[d];
            mop[d]  = mg[d] ? op1[d] : op0[d];
            mx[d]   = mg[d] ? x1[d]  : x0[d];
            my[d]   = mg[d] ? y1[d]  : y0[d];
            mev[d]  = m_inf[d] && (m_n >= m_rn[d]);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n <= 0;
            for (int d = 0; d < 2; d++) begin
                m_inf[d] <= 1'b0; m_last[d] <= 1'b1; m_id[d] <= 1'b0; m_err[d] <= 1'b0;
                m_data[d] <= '0; m_ax[d] <= '0; m_ay[d] <= '0; m_aop[d] <= '0; m_rn[d] <= 0;
            end
        end else begin
            m_n <= m_n + 1;
            for (int d = 0; d < 2; d++) begin
                if (mev[d]) begin
                    if (rr[d]) m_inf[d] <= 1'b0;
                end else if (!m_inf[d] && mvld[d]) begin
                    m_inf[d]  <= 1'b1;
                    m_last[d] <= mg[d];
                    m_id[d]   <= mg[d];
                    m_err[d]  <= !legal(mop[d]);
                    m_data[d] <= legal(mop[d]) ? alu_f(mx[d], my[d], mop[d]) : 16'h0000;
                    m_rn[d]   <= m_n + 1 + (legal(mop[d]) ? settle(d) : 0);
                    if (legal(mop[d])) begin
                        m_ax[d] <= mx[d]; m_ay[d] <= my[d]; m_aop[d] <= mop[d];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d req0_ready", d), 32'(rdy0[d]),
                  32'(!rst && !m_inf[d] && mvld[d] && !mg[d]));
            check($sformatf("dut%0d req1_ready", d), 32'(rdy1[d]),
                  32'(!rst && !m_inf[d] && mvld[d] && mg[d]));
            check($sformatf("dut%0d busy", d), 32'(bsy[d]), 32'(m_inf[d]));
            check($sformatf("dut%0d rsp_valid", d), 32'(rv[d]), 32'(mev[d]));
            check($sformatf("dut%0d alu_x", d), 32'(ax[d]), 32'(m_ax[d]));
            check($sformatf("dut%0d alu_y", d), 32'(ay[d]), 32'(m_ay[d]));
            check($sformatf("dut%0d alu_op", d), 32'(aop[d]), 32'(m_aop[d]));
            if (mev[d]) begin
                check($sformatf("dut%0d rsp_id", d), 32'(rid[d]), 32'(m_id[d]));
                check($sformatf("dut%0d rsp_data", d), 32'(rdata[d]), 32'(m_data[d]));
                check($sformatf("dut%0d rsp_err", d), 32'(rerr[d]), 32'(m_err[d]));
            end
        end
    end

    task automatic drive_req(int d, int n, logic vld, logic [2:0] op, logic [15:0] x, logic [15:0] y);
        if (n == 0) begin v0[d] = vld; op0[d] = op; x0[d] = x; y0[d] = y; end
        else        begin v1[d] = vld; op1[d] = op; x1[d] = x; y1[d] = y; end
    endtask

    // Wait (bounded) until requester n of dut d is accepted, then drop its valid.
    task automatic wait_accept(int d, int n);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (((n == 0) ? rdy0[d] : rdy1[d]) === 1'b1) got = 1'b1;
        end
        check($sformatf("dut%0d req%0d accepted in time", d, n), 32'(got), 32'd1);
        @(posedge clk); #1;
        if (n == 0) v0[d] = 1'b0; else v1[d] = 1'b0;
    endtask

    task automatic send(int d, int n, logic [2:0] op, logic [15:0] x, logic [15:0] y);
        @(posedge clk); #1;
        drive_req(d, n, 1'b1, op, x, y);
        wait_accept(d, n);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic        ids[$];
        logic [15:0] datas[$];
        for (int d = 0; d < 2; d++) begin
            drive_req(d, 0, 1'b0, 3'b000, 16'h0, 16'h0);
            drive_req(d, 1, 1'b0, 3'b000, 16'h0, 16'h0);
        end
        rr[0] = 1'b1;
        rr[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset rsp_data", 32'(rdata[0]), 32'h0);
        check("reset alu_op", 32'(aop[0]), 32'h0);
        check("reset busy", 32'(bsy[1]), 32'h0);

        // ADD 3+4, settle 1: valid two edges after the accept cycle
        send(0, 0, 3'b010, 16'h0003, 16'h0004);
        @(negedge clk);
        check("add alu_op", 32'(aop[0]), 32'h2);
        check("add settling rsp_valid", 32'(rv[0]), 32'h0);
        @(negedge clk);
        check("add rsp_valid", 32'(rv[0]), 32'h1);
        check("add rsp_id", 32'(rid[0]), 32'h0);
        check("add rsp_data", 32'(rdata[0]), 32'h0007);
        check("add rsp_err", 32'(rerr[0]), 32'h0);

        // Both requesters always valid after reset: strict alternation from req0
        pulse_reset();
        drive_req(0, 0, 1'b1, 3'b010, 16'h0001, 16'h0001);
        drive_req(0, 1, 1'b1, 3'b001, 16'h00F0, 16'h000F);
        for (int i = 0; i < 80 && ids.size() < 4; i++) begin
            @(negedge clk);
            if (rv[0] === 1'b1) begin ids.push_back(rid[0]); datas.push_back(rdata[0]); end
        end
        @(posedge clk); #1;
        v0[0] = 1'b0; v1[0] = 1'b0;
        check("rr response count", 32'(ids.size()), 32'd4);
        for (int i = 0; i < ids.size(); i++) begin
            check($sformatf("rr rsp_id[%0d]", i), 32'(ids[i]), 32'(i % 2));
            check($sformatf("rr rsp_data[%0d]", i), 32'(datas[i]), (i % 2) ? 32'h00FF : 32'h0002);
        end

        // Illegal op from req1: immediate error response, ALU inputs untouched
        send(0, 1, 3'b101, 16'h1234, 16'h5678);
        @(negedge clk);
        check("illegal rsp_valid", 32'(rv[0]), 32'h1);
        check("illegal rsp_id", 32'(rid[0]), 32'h1);
        check("illegal rsp_data", 32'(rdata[0]), 32'h0);
        check("illegal rsp_err", 32'(rerr[0]), 32'h1);
        check("illegal alu_op held", 32'(aop[0]), 32'h1);
        check("illegal alu_x held", 32'(ax[0]), 32'h00F0);

        // SUB 0-1 with settle 3 and consumer stalled for 5 cycles
        send(1, 0, 3'b110, 16'h0000, 16'h0001);
        drive_req(1, 1, 1'b1, 3'b010, 16'h0010, 16'h0020);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("sub settle rsp_valid %0d", k), 32'(rv[1]), 32'h0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("sub stall rsp_valid %0d", k), 32'(rv[1]), 32'h1);
            check($sformatf("sub stall rsp_data %0d", k), 32'(rdata[1]), 32'hFFFF);
            check($sformatf("sub stall busy %0d", k), 32'(bsy[1]), 32'h1);
            check($sformatf("sub stall ready %0d", k), 32'({rdy0[1], rdy1[1]}), 32'h0);
        end
        @(posedge clk); #1 rr[1] = 1'b1;
        wait_accept(1, 1);
        repeat (8) @(posedge clk);

        // Reset in the middle of SETTLE discards the ADD
        send(1, 0, 3'b010, 16'h0005, 16'h0006);
        @(negedge clk);
        #1 rst = 1'b1;
        drive_req(1, 0, 1'b1, 3'b010, 16'h0007, 16'h0008);
        #1;
        check("rst rsp_valid", 32'(rv[1]), 32'h0);
        check("rst busy", 32'(bsy[1]), 32'h0);
        check("rst alu_x", 32'(ax[1]), 32'h0);
        check("rst alu_y", 32'(ay[1]), 32'h0);
        check("rst alu_op", 32'(aop[1]), 32'h0);
        check("rst rsp_data", 32'(rdata[1]), 32'h0);
        check("rst rsp_id/err", 32'({rid[1], rerr[1]}), 32'h0);
        check("rst req0_ready", 32'(rdy0[1]), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post-reset req0_ready", 32'(rdy0[1]), 32'h1);
        @(posedge clk); #1 v0[1] = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("post-reset result alu_x", 32'(ax[1]), 32'h0007);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
